qpu_exu_decode_buf: RTL and testbench

Parametrised decode buffer between the QPU IFU/IR stage and the EXU decoder/dispatch. Holds up to `DEPTH` fetched instructions in a FIFO with valid/ready on both sides. At enqueue it tags each entry with a timepoint ID and quantum-class flags. At dequeue it enforces the measure→FMR hazard: an FMR is held while any quantum measurement is outstanding. It also tracks the outstanding measurement count.

---
 rtl/qpu_exu_decode_buf.sv | 168 ++++++++++++++++
 tb/tb_qpu_exu_decode_buf.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpu_exu_decode_buf.sv
// Decode buffer between the QPU instruction fetch stage and the EXU decoder.
// A DEPTH-entry FIFO tags each instruction with a timepoint ID and
// quantum-class flags at enqueue, and holds an FMR at the head while any
// quantum measurement is still outstanding.
module qpu_exu_decode_buf #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int TP_W    = 16,
  parameter int MEAS_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  input  logic               i_prdt_taken,
  input  logic               flush,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_prdt_taken,
  output logic [TP_W-1:0]    o_tp_id,
  output logic               o_new_timepoint,
  output logic               o_measure,
  output logic               o_fmr,
  input  logic               meas_done,
  output logic [MEAS_W-1:0]  meas_outstanding,
  output logic               fmr_stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [MEAS_W-1:0] MAX_MEAS = {MEAS_W{1'b1}};

  // Entry storage
  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [PC_W-1:0]    r_pc    [DEPTH];
  logic               r_prdt  [DEPTH];
  logic [TP_W-1:0]    r_tp    [DEPTH];
  logic               r_ntp   [DEPTH];
  logic               r_meas  [DEPTH];
  logic               r_fmr   [DEPTH];

  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_cnt;
  logic [TP_W-1:0]    r_tp_cnt;
  logic [MEAS_W-1:0]  r_meas_cnt;
  logic [MEAS_W-1:0]  w_meas_nxt;

  logic w_full;
  logic w_empty;
  logic w_enq;
  logic w_deq;
  logic w_hazard;
  logic w_quantum;
  logic w_measure;
  logic w_qwait;
  logic w_fmr;
  logic w_new_tp;
  logic w_meas_inc;
  logic [TP_W-1:0] w_tp_tag;

  // Classification of the incoming instruction word
  assign w_quantum = i_instr[0];
  assign w_measure = w_quantum & (i_instr[9:1] == 9'b011111111);
  assign w_qwait   = ~i_instr[0] & (i_instr[4:0] == 5'b10010);
  assign w_fmr     = (i_instr[4:0] == 5'b11010);
  assign w_new_tp  = w_qwait | (w_quantum & (i_instr[31:29] != 3'b000));
  // An instruction opening a timepoint already carries the new ID
  assign w_tp_tag  = r_tp_cnt + TP_W'(w_new_tp);

  // Full/empty come from registered count only, so i_ready never depends on o_ready
  assign w_full   = (r_cnt == CW'(DEPTH));
  assign w_empty  = (r_cnt == '0);
  assign i_ready  = ~w_full;

  assign w_hazard = (r_fmr[r_rd_ptr] & (r_meas_cnt != '0)) |
                    (r_meas[r_rd_ptr] & (r_meas_cnt == MAX_MEAS));
  assign o_valid   = ~w_empty & ~w_hazard;
  assign fmr_stall = ~w_empty & w_hazard;

  // Flush drops a same-cycle enqueue
  assign w_enq = i_valid & i_ready & ~flush;
  assign w_deq = o_valid & o_ready;
  assign w_meas_inc = w_deq & r_meas[r_rd_ptr];

  assign o_instr          = r_instr[r_rd_ptr];
  assign o_pc             = r_pc[r_rd_ptr];
  assign o_prdt_taken     = r_prdt[r_rd_ptr];
  assign o_tp_id          = r_tp[r_rd_ptr];
  assign o_new_timepoint  = r_ntp[r_rd_ptr];
  assign o_measure        = r_meas[r_rd_ptr];
  assign o_fmr            = r_fmr[r_rd_ptr];
  assign meas_outstanding = r_meas_cnt;

  // Write the tagged entry at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_instr[k] <= '0;
        r_pc[k]    <= '0;
        r_prdt[k]  <= 1'b0;
        r_tp[k]    <= '0;
        r_ntp[k]   <= 1'b0;
        r_meas[k]  <= 1'b0;
        r_fmr[k]   <= 1'b0;
      end
    end else if (w_enq) begin
      r_instr[r_wr_ptr] <= i_instr;
      r_pc[r_wr_ptr]    <= i_pc;
      r_prdt[r_wr_ptr]  <= i_prdt_taken;
      r_tp[r_wr_ptr]    <= w_tp_tag;
      r_ntp[r_wr_ptr]   <= w_new_tp;
      r_meas[r_wr_ptr]  <= w_measure;
      r_fmr[r_wr_ptr]   <= w_fmr;
    end
  end

  // Pointers and occupancy; flush empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_cnt <= r_cnt + CW'(w_enq) - CW'(w_deq);
    end
  end

  // Timepoint counter survives flush and wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tp_cnt <= '0;
    end else if (w_enq) begin
      r_tp_cnt <= w_tp_tag;
    end
  end

  // Outstanding-measurement next value; a done at zero with no issue is ignored
  always_comb begin
    w_meas_nxt = r_meas_cnt;
    if (w_meas_inc && !meas_done) begin
      w_meas_nxt = r_meas_cnt + MEAS_W'(1);
    end else if (!w_meas_inc && meas_done && (r_meas_cnt != '0)) begin
      w_meas_nxt = r_meas_cnt - MEAS_W'(1);
    end
  end

  // Outstanding-measurement register, unaffected by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meas_cnt <= '0;
    end else begin
      r_meas_cnt <= w_meas_nxt;
    end
  end

endmodule

// File: tb/tb_qpu_exu_decode_buf.sv
// Scoreboard bench for qpu_exu_decode_buf: a tracker pushes the expected
// entry on every accepted enqueue, a monitor pops and compares on dequeue,
// and the main sequence adds directed status checks.
module tb_qpu_exu_decode_buf;

  localparam int DEPTH   = 4;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int TP_W    = 16;
  localparam int MEAS_W  = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        prdt;
    logic [15:0] tp;
    logic        ntp;
    logic        meas;
    logic        fmr;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_valid = 1'b0;
  logic               i_ready;
  logic [INSTR_W-1:0] i_instr = '0;
  logic [PC_W-1:0]    i_pc = '0;
  logic               i_prdt_taken = 1'b0;
  logic               flush = 1'b0;
  logic               o_valid;
  logic               o_ready = 1'b0;
  logic [INSTR_W-1:0] o_instr;
  logic [PC_W-1:0]    o_pc;
  logic               o_prdt_taken;
  logic [TP_W-1:0]    o_tp_id;
  logic               o_new_timepoint;
  logic               o_measure;
  logic               o_fmr;
  logic               meas_done = 1'b0;
  logic [MEAS_W-1:0]  meas_outstanding;
  logic               fmr_stall;

  exp_t        sb[$];
  logic [15:0] tp_m = 16'h0;
  int          n_vec = 0;
  int          n_err = 0;

  qpu_exu_decode_buf #(
    .DEPTH(DEPTH), .INSTR_W(INSTR_W), .PC_W(PC_W), .TP_W(TP_W), .MEAS_W(MEAS_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_instr(i_instr), .i_pc(i_pc),
    .i_prdt_taken(i_prdt_taken), .flush(flush),
    .o_valid(o_valid), .o_ready(o_ready), .o_instr(o_instr), .o_pc(o_pc),
    .o_prdt_taken(o_prdt_taken), .o_tp_id(o_tp_id),
    .o_new_timepoint(o_new_timepoint), .o_measure(o_measure), .o_fmr(o_fmr),
    .meas_done(meas_done), .meas_outstanding(meas_outstanding),
    .fmr_stall(fmr_stall)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic p, input logic [15:0] tp_now);
    exp_t m;
    logic q, qw;
    q      = ins[0];
    qw     = !ins[0] && (ins[4:0] == 5'h12);
    m.instr = ins;
    m.pc    = pc;
    m.prdt  = p;
    m.meas  = q && (ins[9:1] == 9'h0FF);
    m.fmr   = (ins[4:0] == 5'h1A);
    m.ntp   = qw || (q && (ins[31:29] != 3'd0));
    m.tp    = tp_now + {15'd0, m.ntp};
    return m;
  endfunction

  // Tracker: expected entry for every accepted enqueue
  initial begin : tracker
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        tp_m = 16'h0;
      end else if (flush) begin
        sb.delete();
      end else if (i_valid && i_ready) begin
        e = model(i_instr, i_pc, i_prdt_taken, tp_m);
        sb.push_back(e);
        tp_m = e.tp;
      end
    end
  end

  // Monitor: compare every dequeued head entry
  initial begin : monitor
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      if (rst_n && o_valid && o_ready) begin
        got = {o_instr, o_pc, o_prdt_taken, o_tp_id, o_new_timepoint, o_measure, o_fmr};
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL deq_unexpected: got %h required none", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL deq: got %h required %h", got, e);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] ins, input logic [31:0] pc);
    i_valid      = 1'b1;
    i_instr      = ins;
    i_pc         = pc;
    i_prdt_taken = pc[2];
    cyc(1);
    i_valid      = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_i_ready", 64'(i_ready), 64'd1);
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_stall", 64'(fmr_stall), 64'd0);
    chk("rst_meas", 64'(meas_outstanding), 64'd0);
    chk("rst_payload", 64'({o_instr, o_tp_id, o_new_timepoint, o_measure, o_fmr, o_prdt_taken}), 64'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // Fill to full, then drain in order
    for (int k = 0; k < 4; k++) enq(32'h1000_0000 | (32'(k) << 8), 32'h100 + 32'(4 * k));
    chk("full_i_ready", 64'(i_ready), 64'd0);
    chk("full_head_pc", 64'(o_pc), 64'h100);
    enq(32'h1000_0400, 32'h110);
    chk("full_5th_blocked", 64'(i_ready), 64'd0);
    o_ready = 1'b1;
    cyc(4);
    chk("drained", 64'(o_valid), 64'd0);
    o_ready = 1'b0;

    // Timepoint tags
    enq(32'h0000_0012, 32'h200);
    enq(32'h0000_0001, 32'h204);
    enq(32'h6000_0001, 32'h208);
    chk("tp_qwait", 64'({o_tp_id, o_new_timepoint}), {47'd0, 16'd1, 1'b1});
    o_ready = 1'b1;
    cyc(1);
    chk("tp_pi0", 64'({o_tp_id, o_new_timepoint}), {47'd0, 16'd1, 1'b0});
    cyc(1);
    chk("tp_pi3", 64'({o_tp_id, o_new_timepoint}), {47'd0, 16'd2, 1'b1});
    cyc(1);
    o_ready = 1'b0;

    // Measure then FMR hazard
    enq(32'h0000_01FF, 32'h300);
    enq(32'h0000_001A, 32'h304);
    chk("haz_head_meas", 64'({o_valid, o_measure}), 64'b11);
    o_ready = 1'b1;
    cyc(1);
    chk("haz_meas_cnt", 64'(meas_outstanding), 64'd1);
    chk("haz_blocked", 64'({o_valid, fmr_stall, o_fmr}), 64'b011);
    cyc(1);
    chk("haz_still", 64'({o_valid, fmr_stall}), 64'b01);
    meas_done = 1'b1;
    cyc(1);
    meas_done = 1'b0;
    chk("haz_release", 64'({o_valid, fmr_stall, meas_outstanding}), {61'd0, 1'b1, 1'b0, 2'd0});
    cyc(1);
    chk("haz_issued", 64'({o_valid, fmr_stall}), 64'b00);

    // Counter saturation at MAX_MEAS = 3
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_instr = 32'h0000_01FF; i_pc = 32'h400 + 32'(4 * k); i_prdt_taken = 1'b0;
      cyc(1);
    end
    i_valid = 1'b0;
    chk("sat_cnt", 64'(meas_outstanding), 64'd3);
    chk("sat_stall", 64'({o_valid, fmr_stall}), 64'b01);
    meas_done = 1'b1;
    cyc(1);
    chk("sat_dec", 64'({o_valid, meas_outstanding}), {61'd0, 1'b1, 2'd2});
    cyc(1);
    chk("sat_inc_dec", 64'({o_valid, meas_outstanding}), {61'd0, 1'b0, 2'd2});
    cyc(1);
    chk("sat_dec1", 64'(meas_outstanding), 64'd1);
    cyc(1);
    chk("sat_dec0", 64'(meas_outstanding), 64'd0);
    cyc(1);
    chk("sat_no_underflow", 64'(meas_outstanding), 64'd0);
    meas_done = 1'b0;

    // Flush with a simultaneous enqueue
    enq(32'h0000_01FF, 32'h500);
    cyc(1);
    chk("fl_meas_pre", 64'(meas_outstanding), 64'd1);
    o_ready = 1'b0;
    enq(32'h0000_0012, 32'h504);
    enq(32'h0000_0004, 32'h508);
    enq(32'h0000_0008, 32'h50C);
    chk("fl_head_tp", 64'({o_valid, o_tp_id}), {47'd0, 1'b1, 16'd3});
    flush = 1'b1; i_valid = 1'b1; i_instr = 32'h0000_0012; i_pc = 32'h510;
    cyc(1);
    flush = 1'b0; i_valid = 1'b0;
    chk("fl_empty", 64'({o_valid, fmr_stall, i_ready}), 64'b001);
    chk("fl_meas_kept", 64'(meas_outstanding), 64'd1);
    enq(32'h0000_0012, 32'h514);
    chk("fl_tp_kept", 64'({o_valid, o_tp_id, o_pc}), {15'd0, 1'b1, 16'd4, 32'h514});
    o_ready = 1'b1; meas_done = 1'b1;
    cyc(1);
    meas_done = 1'b0;
    chk("fl_after", 64'({o_valid, meas_outstanding}), 64'd0);

    // Timepoint wrap: stream qwaits until tp_cnt = 16'hFFFF
    i_valid = 1'b1; i_instr = 32'h0000_0012; i_prdt_taken = 1'b0;
    for (int k = 0; k < 65531; k++) begin
      i_pc = 32'(k);
      cyc(1);
    end
    i_valid = 1'b0;
    cyc(2);
    o_ready = 1'b0;
    enq(32'h0000_0012, 32'hABC);
    chk("tp_wrap", 64'({o_tp_id, o_new_timepoint}), {47'd0, 16'h0000, 1'b1});
    o_ready = 1'b1;
    cyc(1);
    chk("tp_wrap_drain", 64'(o_valid), 64'd0);

    // Async reset with a full FIFO and an outstanding measurement
    enq(32'h0000_01FF, 32'h600);
    cyc(1);
    chk("ar_meas_pre", 64'(meas_outstanding), 64'd1);
    o_ready = 1'b0;
    for (int k = 0; k < 4; k++) enq(32'hCAFE_0000 | (32'(k) << 8), 32'h700 + 32'(4 * k));
    chk("ar_full", 64'({i_ready, o_valid, o_pc}), {30'd0, 1'b0, 1'b1, 32'h700});
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_ctrl", 64'({o_valid, fmr_stall, i_ready, meas_outstanding}), {59'd0, 3'b001, 2'd0});
    chk("ar_payload", 64'({o_instr, o_pc}), 64'd0);
    chk("ar_flags", 64'({o_tp_id, o_new_timepoint, o_measure, o_fmr, o_prdt_taken}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1);
    chk("ar_release", 64'({o_valid, i_ready}), 64'b01);
    enq(32'h0000_0012, 32'h800);
    chk("ar_tp_restart", 64'(o_tp_id), 64'd1);
    o_ready = 1'b1;
    cyc(1);
    chk("ar_drain", 64'(o_valid), 64'd0);

    cyc(2);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
